// File: rtl/ecc_apb_sequencer.sv
// ecc_apb_sequencer: APB master that programs one ecc_enc_dec per request and returns its result.
//   Request side : req_valid/req_ready handshake carrying ctrl, data, codeword width and noise.
//   Response side: rsp_valid/rsp_ready handshake carrying data_out, num_of_errors and a timeout flag.
//   APB side     : psel/penable/pwrite/paddr/pwdata (write-only, no pready), plus operation_done,
//                  data_out and num_of_errors from the ecc_enc_dec instance.
//   clk rising edge, rst asynchronous active-low.
module ecc_apb_sequencer #(
  parameter int DATA_WIDTH      = 32,
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_ctrl,
  input  logic [DATA_WIDTH-1:0]      req_data,
  input  logic [1:0]                 req_width,
  input  logic [DATA_WIDTH-1:0]      req_noise,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic [1:0]                 rsp_num_err,
  output logic                       rsp_timeout,
  output logic                       psel,
  output logic                       penable,
  output logic                       pwrite,
  output logic [AMBA_ADDR_WIDTH-1:0] paddr,
  output logic [AMBA_WORD-1:0]       pwdata,
  input  logic                       operation_done,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic [1:0]                 num_of_errors
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WAIT_DONE, RESP} state_t;
  state_t                r_state;
  logic [1:0]            r_idx;
  logic [1:0]            r_ctrl;
  logic [1:0]            r_width;
  logic [DATA_WIDTH-1:0] r_noise;
  logic [CW-1:0]         r_cnt;
  logic [1:0]                 w_nidx;
  logic [AMBA_ADDR_WIDTH-1:0] w_naddr;
  logic [AMBA_WORD-1:0]       w_nwdata;
  // Address/data of the next transfer; write order is DATA_IN, CODEWORD_WIDTH, NOISE, CTRL.
  // DATA_IN (index 0) is loaded straight from the request at accept, so r_data is never needed.
  assign w_nidx = r_idx + 2'd1;
  always_comb begin
    w_naddr  = AMBA_ADDR_WIDTH'(w_nidx == 2'd1 ? 8 : w_nidx == 2'd2 ? 12 : 0);
    w_nwdata = w_nidx == 2'd1 ? AMBA_WORD'(r_width) :
               w_nidx == 2'd2 ? AMBA_WORD'(r_noise) : AMBA_WORD'(r_ctrl);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_ctrl      <= '0;
      r_width     <= '0;
      r_noise     <= '0;
      r_cnt       <= '0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_num_err <= '0;
      rsp_timeout <= 1'b0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
    end else begin
      case (r_state)
        IDLE: if (req_valid && req_ready) begin
          r_ctrl    <= req_ctrl;
          r_width   <= req_width;
          r_noise   <= req_noise;
          r_idx     <= '0;
          req_ready <= 1'b0;
          psel      <= 1'b1;
          pwrite    <= 1'b1;
          paddr     <= AMBA_ADDR_WIDTH'(4);
          pwdata    <= AMBA_WORD'(req_data);
          r_state   <= SETUP;
        end
        SETUP: begin
          penable <= 1'b1;
          r_state <= ACCESS;
        end
        ACCESS: begin
          penable <= 1'b0;
          if (r_idx != 2'd3) begin
            r_idx   <= w_nidx;
            paddr   <= w_naddr;
            pwdata  <= w_nwdata;
            r_state <= SETUP;
          end else begin
            psel    <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
            r_cnt   <= '0;
            r_state <= WAIT_DONE;
          end
        end
        WAIT_DONE: if (operation_done) begin
          rsp_data    <= data_out;
          rsp_num_err <= num_of_errors;
          rsp_timeout <= 1'b0;
          rsp_valid   <= 1'b1;
          r_state     <= RESP;
        end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          rsp_data    <= '0;
          rsp_num_err <= '0;
          rsp_timeout <= 1'b1;
          rsp_valid   <= 1'b1;
          r_state     <= RESP;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          r_cnt     <= '0;
          req_ready <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ecc_apb_sequencer.sv
// tb_ecc_apb_sequencer: directed self-checking bench for ecc_apb_sequencer.
module tb_ecc_apb_sequencer;
  localparam int DW = 32, AW = 32, ADW = 32, TO = 16;
  logic           clk = 1'b0, rst = 1'b0;
  logic           req_valid = 1'b0, req_ready;
  logic [1:0]     req_ctrl = '0, req_width = '0;
  logic [DW-1:0]  req_data = '0, req_noise = '0;
  logic           rsp_valid, rsp_ready = 1'b0, rsp_timeout;
  logic [DW-1:0]  rsp_data;
  logic [1:0]     rsp_num_err;
  logic           psel, penable, pwrite;
  logic [ADW-1:0] paddr;
  logic [AW-1:0]  pwdata;
  logic           operation_done = 1'b0;
  logic [DW-1:0]  data_out = '0;
  logic [1:0]     num_of_errors = '0;
  int n_chk = 0, n_pass = 0;
  ecc_apb_sequencer #(.DATA_WIDTH(DW), .AMBA_WORD(AW), .AMBA_ADDR_WIDTH(ADW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_ctrl(req_ctrl),
    .req_data(req_data), .req_width(req_width), .req_noise(req_noise), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_num_err(rsp_num_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .operation_done(operation_done), .data_out(data_out), .num_of_errors(num_of_errors)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_apb"}, {psel, penable, pwrite}, 3'b000);
    chk({tag, "_paddr"}, paddr, 0);
    chk({tag, "_pwdata"}, pwdata, 0);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_rsp"}, {rsp_valid, rsp_timeout, rsp_num_err}, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
  endtask
  task automatic send(input logic [1:0] c, input logic [31:0] d, input logic [1:0] w, input logic [31:0] nz);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_ctrl = c; req_data = d; req_width = w; req_noise = nz;
    @(negedge clk);
    req_valid = 1'b0;
  endtask
  task automatic apb(input logic [1:0] c, input logic [31:0] d, input logic [1:0] w, input logic [31:0] nz, input bit stray);
    logic [31:0] a [4];
    logic [31:0] v [4];
    a = '{32'h4, 32'h8, 32'hC, 32'h0};
    v = '{d, {30'd0, w}, nz, {30'd0, c}};
    for (int i = 0; i < 4; i++) begin
      chk("setup_ctl", {psel, penable, pwrite}, 3'b101);
      chk("setup_addr", paddr, a[i]);
      chk("setup_data", pwdata, v[i]);
      chk("busy_req_ready", req_ready, 0);
      if (stray && i == 0) begin
        operation_done = 1'b1;
        data_out = 32'hDEAD;
        req_data = ~d; req_noise = ~nz; req_ctrl = ~c; req_width = ~w;
      end
      @(negedge clk);
      operation_done = 1'b0;
      chk("access_ctl", {psel, penable, pwrite}, 3'b111);
      chk("access_addr", paddr, a[i]);
      chk("access_data", pwdata, v[i]);
      @(negedge clk);
    end
    chk("wait_apb_idle", {psel, penable, pwrite}, 3'b000);
  endtask
  task automatic finish_op(input logic [31:0] dout, input logic [1:0] ne);
    chk("rsp_not_yet", rsp_valid, 0);
    operation_done = 1'b1; data_out = dout; num_of_errors = ne;
    @(negedge clk);
    operation_done = 1'b0;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_data", rsp_data, dout);
    chk("rsp_num_err", rsp_num_err, ne);
    chk("rsp_timeout", rsp_timeout, 0);
  endtask
  task automatic ack;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 0);
    chk("req_ready_back", req_ready, 1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b1;
    // Encode
    send(2'd0, 32'hA5, 2'd2, 32'h0);
    apb(2'd0, 32'hA5, 2'd2, 32'h0, 1'b0);
    finish_op(32'h1234, 2'd0);
    ack();
    // Decode, one error, minimum latency, then backpressure
    send(2'd1, 32'hA5, 2'd2, 32'h1);
    apb(2'd1, 32'hA5, 2'd2, 32'h1, 1'b0);
    finish_op(32'hA5, 2'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 32'hA5);
      chk("bp_err", rsp_num_err, 2'd1);
      chk("bp_req_ready", req_ready, 0);
    end
    ack();
    // Timeout: done never comes, rsp appears after TO wait cycles
    send(2'd1, 32'h55, 2'd0, 32'h0);
    apb(2'd1, 32'h55, 2'd0, 32'h0, 1'b0);
    data_out = 32'hFFFF_FFFF; num_of_errors = 2'd3;
    for (int k = 0; k < TO; k++) begin
      chk("to_wait_quiet", {psel, penable, rsp_valid}, 3'b000);
      @(negedge clk);
    end
    chk("to_valid", rsp_valid, 1);
    chk("to_flag", rsp_timeout, 1);
    chk("to_data", rsp_data, 0);
    chk("to_err", rsp_num_err, 0);
    ack();
    // Reset during ACCESS of the NOISE write
    send(2'd0, 32'h11, 2'd1, 32'h22);
    repeat (5) @(negedge clk);
    chk("pre_rst_noise_access", {penable, paddr}, {1'b1, 32'hC});
    rst = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b1;
    send(2'd2, 32'h0F0F, 2'd1, 32'h10);
    apb(2'd2, 32'h0F0F, 2'd1, 32'h10, 1'b0);
    finish_op(32'hBEEF, 2'd2);
    ack();
    // Stray done during SETUP and request fields changing while busy
    send(2'd0, 32'h3C, 2'd3, 32'h0);
    apb(2'd0, 32'h3C, 2'd3, 32'h0, 1'b1);
    req_data = 32'h9999; req_ctrl = 2'd2;
    repeat (2) @(negedge clk);
    chk("stray_no_apb", {psel, penable}, 2'b00);
    finish_op(32'h77, 2'd0);
    ack();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
